// File: rtl/id.sv
// Instruction-decode stage: field split, 8x16 register file with three
// read ports, and per-opcode control bits for the downstream stages.
module id #(
  parameter int ARQ = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ARQ-1:0] instr,
  input  logic [ARQ-1:0] wb_result,
  input  logic           wr_register,
  output logic [ARQ-1:0] out1,
  output logic [ARQ-1:0] out2,
  output logic [ARQ-1:0] out3,
  output logic [9:0]     imm,
  output logic [13:0]    addr,
  output logic           jop_lsb,
  output logic           rd_mem_en,
  output logic           wr_mem_en,
  output logic           mux_exe,
  output logic           mux_mem,
  output logic           jenable,
  output logic           wb_enable,
  output logic [1:0]     alu_op
);

  typedef enum logic [2:0] {
    OP_SET   = 3'b000,
    OP_LDPX  = 3'b001,
    OP_MODEX = 3'b010,
    OP_STPX  = 3'b011,
    OP_CMPEQ = 3'b100,
    OP_JEQ   = 3'b101,
    OP_J     = 3'b110,
    OP_ADD   = 3'b111
  } opcode_e;

  typedef struct packed {
    logic       wb;
    logic       rd_mem;
    logic       wr_mem;
    logic       mx_exe;
    logic       mx_mem;
    logic       jmp;
    logic [1:0] alu;
  } ctrl_t;

  opcode_e    opc;
  logic [2:0] rd_a;
  logic [2:0] rs1_a;
  logic [2:0] rs2_a;

  assign opc   = opcode_e'(instr[15:13]);
  assign rd_a  = instr[12:10];
  assign rs1_a = instr[9:7];
  assign rs2_a = instr[6:4];

  logic [ARQ-1:0] rf_q [8];

  // The write address comes from the instruction present at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_register) begin
      rf_q[rd_a] <= wb_result;
    end
  end

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    unique case (opc)
      OP_SET:   ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11};
      OP_LDPX:  ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11};
      OP_MODEX: ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
      OP_STPX:  ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
      OP_CMPEQ: ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
      OP_JEQ:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      OP_J:     ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      OP_ADD:   ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      default:  ctrl = '0;
    endcase
  end

  // Every output is held at zero for the whole time reset is low.
  always_comb begin
    out1      = '0;
    out2      = '0;
    out3      = '0;
    imm       = '0;
    addr      = '0;
    jop_lsb   = 1'b0;
    rd_mem_en = 1'b0;
    wr_mem_en = 1'b0;
    mux_exe   = 1'b0;
    mux_mem   = 1'b0;
    jenable   = 1'b0;
    wb_enable = 1'b0;
    alu_op    = 2'b00;
    if (rst) begin
      out1      = rf_q[rd_a];
      out2      = rf_q[rs1_a];
      out3      = rf_q[rs2_a];
      imm       = instr[9:0];
      addr      = {1'b0, instr[12:0]};
      jop_lsb   = instr[13];
      wb_enable = ctrl.wb;
      rd_mem_en = ctrl.rd_mem;
      wr_mem_en = ctrl.wr_mem;
      mux_exe   = ctrl.mx_exe;
      mux_mem   = ctrl.mx_mem;
      jenable   = ctrl.jmp;
      alu_op    = ctrl.alu;
    end
  end

endmodule

// File: tb/tb_id.sv
// Scoreboard bench for the decode stage: stimulus pushes expected outputs,
// a monitor pops and compares them mid-cycle against the DUT.
module tb_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic [15:0] wb_result;
  logic        wr_register;
  logic [15:0] out1, out2, out3;
  logic [9:0]  imm;
  logic [13:0] addr;
  logic        jop_lsb, rd_mem_en, wr_mem_en, mux_exe, mux_mem;
  logic        jenable, wb_enable;
  logic [1:0]  alu_op;

  id dut (
    .clk(clk), .rst(rst), .instr(instr), .wb_result(wb_result),
    .wr_register(wr_register), .out1(out1), .out2(out2), .out3(out3),
    .imm(imm), .addr(addr), .jop_lsb(jop_lsb), .rd_mem_en(rd_mem_en),
    .wr_mem_en(wr_mem_en), .mux_exe(mux_exe), .mux_mem(mux_mem),
    .jenable(jenable), .wb_enable(wb_enable), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o1, o2, o3;
    logic [9:0]  im;
    logic [13:0] ad;
    logic        jl;
    logic [7:0]  ct;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] mrf [8];
  logic [7:0]  tab [8];

  // wb, rd_mem, wr_mem, mux_exe, mux_mem, jenable, alu_op[1:0]
  initial begin
    tab[0] = 8'b1_0_0_1_0_0_11;
    tab[1] = 8'b1_1_0_0_1_0_11;
    tab[2] = 8'b1_0_0_0_0_0_01;
    tab[3] = 8'b0_0_1_0_0_0_11;
    tab[4] = 8'b0_0_0_0_0_0_10;
    tab[5] = 8'b0_0_0_0_0_1_00;
    tab[6] = 8'b0_0_0_0_0_1_00;
    tab[7] = 8'b1_0_0_1_0_0_00;
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, req, $time);
    end
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out1", out1, e.o1);
      chk("out2", out2, e.o2);
      chk("out3", out3, e.o3);
      chk("imm", {6'd0, imm}, {6'd0, e.im});
      chk("addr", {2'd0, addr}, {2'd0, e.ad});
      chk("jop_lsb", {15'd0, jop_lsb}, {15'd0, e.jl});
      chk("ctrl", {8'd0, wb_enable, rd_mem_en, wr_mem_en, mux_exe,
                   mux_mem, jenable, alu_op}, {8'd0, e.ct});
    end
  end

  task automatic step(logic [15:0] i, logic [15:0] wb, logic wr, logic r);
    exp_t e;
    @(negedge clk);
    instr = i;
    wb_result = wb;
    wr_register = wr;
    rst = r;
    if (!r) begin
      for (int k = 0; k < 8; k++) mrf[k] = '0;
      e = '{16'd0, 16'd0, 16'd0, 10'd0, 14'd0, 1'b0, 8'd0};
    end else begin
      e.o1 = mrf[i[12:10]];
      e.o2 = mrf[i[9:7]];
      e.o3 = mrf[i[6:4]];
      e.im = i[9:0];
      e.ad = {1'b0, i[12:0]};
      e.jl = i[13];
      e.ct = tab[i[15:13]];
    end
    sb.push_back(e);
    @(posedge clk);
    if (r && wr) mrf[i[12:10]] = wb;
  endtask

  initial begin
    rst = 1'b0;
    instr = 16'hFFFF;
    wb_result = 16'h1234;
    wr_register = 1'b1;
    for (int k = 0; k < 8; k++) mrf[k] = 'x;
    step(16'hFFFF, 16'h1234, 1'b1, 1'b0);
    step(16'hA5C3, 16'h5555, 1'b1, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b1);
    step(16'h0800, 16'd0,   1'b1, 1'b1);
    step(16'h0400, 16'd451, 1'b1, 1'b1);
    step(16'h0000, 16'd555, 1'b1, 1'b1);
    step(16'h0013, 16'd0,   1'b0, 1'b1);
    step(16'h40A0, 16'd0,   1'b0, 1'b1);
    step(16'h2500, 16'd150, 1'b1, 1'b1);
    step(16'h2500, 16'd0,   1'b0, 1'b1);
    step(16'h7380, 16'd0,   1'b0, 1'b1);
    step(16'h82E0, 16'd0,   1'b0, 1'b1);
    step(16'hA004, 16'd0,   1'b0, 1'b1);
    step(16'hC005, 16'd0,   1'b0, 1'b1);
    step(16'hEC0F, 16'd100, 1'b1, 1'b1);
    step(16'hEC0F, 16'd0,   1'b0, 1'b1);
    // Mid-run reset must clear the file, then writes while low are ignored.
    step(16'hEC0F, 16'hBEEF, 1'b1, 1'b0);
    step(16'hEC0F, 16'd0,   1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      step(16'($urandom), 16'($urandom), 1'($urandom),
           ($urandom_range(0, 39) != 0));
    end
    @(negedge clk);
    #5;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
